// File: rtl/regfile_write_scheduler_pkg.sv
// rtl/regfile_write_scheduler_pkg.sv - shared widths, requester IDs and helpers for the write scheduler
//
// Purpose:
//   Common definitions for the register-file write scheduler and its sub-modules.
// Contents:
//   DATA_W, SEL_W, NUM_REGS - write data width, register select width, register count
//   req_id_t                - writeback requester ID; the value doubles as a bit index
//                             into request/grant vectors
//   wr_req_t                - one write request (destination select + data)
//   sel_onehot()            - register select to one-hot scoreboard mask

package regfile_write_scheduler_pkg;

    localparam int DATA_W   = 16;
    localparam int SEL_W    = 4;
    localparam int NUM_REGS = 16;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_t;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    function automatic logic [NUM_REGS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_REGS-1:0] mask;
        mask      = '0;
        mask[sel] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// rtl/regfile_write_scheduler_if.sv - bus bundle between pipeline stages, decode and the write scheduler
//
// Purpose:
//   Groups every non-clock/reset signal of the scheduler.
// Signal groups:
//   alu_valid/alu_sel/alu_data/alu_ready - ALU writeback request and grant
//   mem_valid/mem_sel/mem_data/mem_ready - MEM writeback request and grant
//   write_enable/select_input/write_data - registered register-file write port
//   reserve/reserve_sel/reserve_ready    - decode destination reservation
//   select_a/select_b/busy_a/busy_b      - decode operand scoreboard lookup
// Modports:
//   master - the requesters and decode (drive requests, observe results)
//   slave  - the scheduler itself

interface regfile_write_scheduler_if;
    import regfile_write_scheduler_pkg::*;

    logic              alu_valid;
    logic [SEL_W-1:0]  alu_sel;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              mem_valid;
    logic [SEL_W-1:0]  mem_sel;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              write_enable;
    logic [SEL_W-1:0]  select_input;
    logic [DATA_W-1:0] write_data;

    logic              reserve;
    logic [SEL_W-1:0]  reserve_sel;
    logic              reserve_ready;

    logic [SEL_W-1:0]  select_a;
    logic [SEL_W-1:0]  select_b;
    logic              busy_a;
    logic              busy_b;

    modport master (
        output alu_valid, alu_sel, alu_data,
        input  alu_ready,
        output mem_valid, mem_sel, mem_data,
        input  mem_ready,
        input  write_enable, select_input, write_data,
        output reserve, reserve_sel,
        input  reserve_ready,
        output select_a, select_b,
        input  busy_a, busy_b
    );

    modport slave (
        input  alu_valid, alu_sel, alu_data,
        output alu_ready,
        input  mem_valid, mem_sel, mem_data,
        output mem_ready,
        output write_enable, select_input, write_data,
        input  reserve, reserve_sel,
        output reserve_ready,
        input  select_a, select_b,
        output busy_a, busy_b
    );

endinterface

// File: rtl/regfile_write_scheduler_rr_arbiter2.sv
// rtl/regfile_write_scheduler_rr_arbiter2.sv - two-way round-robin arbiter with a last-grant flop
//
// Purpose:
//   Grants one of two requesters per cycle. A lone requester always wins; under
//   contention the requester that did not win most recently is granted.
// Ports:
//   i_clk    in  1  clock, rising edge
//   i_rst    in  1  asynchronous active-high reset (last grant -> MEM)
//   i_req    in  2  request vector, indexed by req_id_t
//   o_grant  out 2  one-hot (or zero) grant vector, combinational
//   o_winner out 1  granted requester ID, meaningful only when |o_grant

module rr_arbiter2
    import regfile_write_scheduler_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant,
    output req_id_t    o_winner
);

    req_id_t r_last_grant;
    req_id_t w_last_grant_next;

    // Resetting to MEM makes ALU the winner of the first contention.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_grant <= REQ_MEM;
        end else begin
            r_last_grant <= w_last_grant_next;
        end
    end

    always_comb begin
        w_last_grant_next = r_last_grant;
        if (|o_grant) begin
            w_last_grant_next = o_winner;
        end
    end

    always_comb begin
        o_grant  = 2'b00;
        o_winner = REQ_ALU;
        if (i_req[REQ_ALU] && (!i_req[REQ_MEM] || (r_last_grant == REQ_MEM))) begin
            o_grant[REQ_ALU] = 1'b1;
            o_winner         = REQ_ALU;
        end else if (i_req[REQ_MEM]) begin
            o_grant[REQ_MEM] = 1'b1;
            o_winner         = REQ_MEM;
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// rtl/regfile_write_scheduler.sv - shares the register-file write port between ALU and MEM and tracks pending writes
//
// Purpose:
//   Round-robin arbitrates ALU and MEM writebacks onto the single register-file
//   write port (one registered write per cycle, 1-cycle grant->strobe latency)
//   and keeps a 16-bit pending-write scoreboard for decode.
// Ports:
//   i_clk in  1  clock, rising edge
//   i_rst in  1  asynchronous active-high reset
//   bus   slave modport of regfile_write_scheduler_if:
//         alu_*/mem_*             writeback requests in, ready (grant) out
//         write_enable/select_input/write_data  registered write port out
//         reserve/reserve_sel in, reserve_ready out
//         select_a/select_b in, busy_a/busy_b out

module regfile_write_scheduler
    import regfile_write_scheduler_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    regfile_write_scheduler_if.slave  bus
);

    logic [1:0]          w_req;
    logic [1:0]          w_grant;
    req_id_t             w_winner;
    wr_req_t             w_alu_req;
    wr_req_t             w_mem_req;
    wr_req_t             w_win_req;

    logic                r_we;
    logic [SEL_W-1:0]    r_sel;
    logic [DATA_W-1:0]   r_data;

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_next;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_set_mask;
    logic                w_reserve_ready;
    logic                w_reserve_fire;

    // Request vector bit positions follow the requester IDs.
    assign w_req[REQ_ALU] = bus.alu_valid;
    assign w_req[REQ_MEM] = bus.mem_valid;

    rr_arbiter2 u_arb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_req    (w_req),
        .o_grant  (w_grant),
        .o_winner (w_winner)
    );

    assign w_alu_req = '{sel: bus.alu_sel, data: bus.alu_data};
    assign w_mem_req = '{sel: bus.mem_sel, data: bus.mem_data};
    assign w_win_req = (w_winner == REQ_MEM) ? w_mem_req : w_alu_req;

    // Write port: strobe for exactly one cycle per grant; select/data hold
    // their last written values while idle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we   <= 1'b0;
            r_sel  <= '0;
            r_data <= '0;
        end else if (|w_grant) begin
            r_we   <= 1'b1;
            r_sel  <= w_win_req.sel;
            r_data <= w_win_req.data;
        end else begin
            r_we   <= 1'b0;
        end
    end

    // A busy register may be re-reserved in the very cycle its write lands,
    // since the clear and the new set resolve to "still busy".
    assign w_reserve_ready = ~r_busy[bus.reserve_sel] | (r_we & (r_sel == bus.reserve_sel));
    assign w_reserve_fire  = bus.reserve & w_reserve_ready;

    always_comb begin
        w_clr_mask  = r_we           ? sel_onehot(r_sel)           : '0;
        w_set_mask  = w_reserve_fire ? sel_onehot(bus.reserve_sel) : '0;
        // Set applied after clear so a same-cycle set/clear leaves the bit set.
        w_busy_next = (r_busy & ~w_clr_mask) | w_set_mask;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign bus.alu_ready     = w_grant[REQ_ALU];
    assign bus.mem_ready     = w_grant[REQ_MEM];
    assign bus.write_enable  = r_we;
    assign bus.select_input  = r_sel;
    assign bus.write_data    = r_data;
    assign bus.reserve_ready = w_reserve_ready;
    // No bypass from the write port: a register still reads busy in its write cycle.
    assign bus.busy_a        = r_busy[bus.select_a];
    assign bus.busy_b        = r_busy[bus.select_b];

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb/tb_regfile_write_scheduler.sv - self-checking bench for regfile_write_scheduler

module tb_regfile_write_scheduler;
    import regfile_write_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_write_scheduler_if bus ();

    regfile_write_scheduler dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit          av;
        logic [3:0]  as;
        logic [15:0] ad;
        bit          mv;
        logic [3:0]  ms;
        logic [15:0] md;
        bit          exp_ar;
        bit          exp_mr;
        bit          exp_we;
        logic [3:0]  exp_sel;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl [9];

    // reference model state for the random run
    wr_req_t     wr_q [$];
    bit          busy_m [16];
    bit          prefer_alu;
    bit          cur_we;
    logic [3:0]  cur_sel;
    wr_req_t     last_wr;
    bit          a_v, m_v, a_done, m_done, ga, gm, rr;
    logic [3:0]  a_s, m_s;
    logic [15:0] a_d, m_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid   = 1'b0;
        bus.alu_sel     = '0;
        bus.alu_data    = '0;
        bus.mem_valid   = 1'b0;
        bus.mem_sel     = '0;
        bus.mem_data    = '0;
        bus.reserve     = 1'b0;
        bus.reserve_sel = '0;
        bus.select_a    = '0;
        bus.select_b    = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drive_alu(input bit v, input logic [3:0] s, input logic [15:0] d);
        bus.alu_valid = v;
        bus.alu_sel   = s;
        bus.alu_data  = d;
    endtask

    task automatic drive_mem(input bit v, input logic [3:0] s, input logic [15:0] d);
        bus.mem_valid = v;
        bus.mem_sel   = s;
        bus.mem_data  = d;
    endtask

    task automatic check_write(input string name, input bit we, input logic [3:0] s, input logic [15:0] d);
        check({name, "_we"},   32'(bus.write_enable), 32'(we));
        check({name, "_sel"},  32'(bus.select_input), 32'(s));
        check({name, "_data"}, 32'(bus.write_data),   32'(d));
    endtask

    initial begin
        //                av as     ad        mv ms      md        ar mr we sel     data
        tbl[0] = '{1'b1, 4'd3,  16'h1111, 1'b1, 4'd9,  16'h2222, 1'b1, 1'b0, 1'b1, 4'd3,  16'h1111};
        tbl[1] = '{1'b1, 4'd4,  16'h3333, 1'b1, 4'd9,  16'h2222, 1'b0, 1'b1, 1'b1, 4'd9,  16'h2222};
        tbl[2] = '{1'b1, 4'd4,  16'h3333, 1'b0, 4'd0,  16'h0000, 1'b1, 1'b0, 1'b1, 4'd4,  16'h3333};
        tbl[3] = '{1'b1, 4'd5,  16'h4444, 1'b1, 4'd10, 16'h5555, 1'b0, 1'b1, 1'b1, 4'd10, 16'h5555};
        tbl[4] = '{1'b1, 4'd5,  16'h4444, 1'b1, 4'd11, 16'h6666, 1'b1, 1'b0, 1'b1, 4'd5,  16'h4444};
        tbl[5] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd11, 16'h6666, 1'b0, 1'b1, 1'b1, 4'd11, 16'h6666};
        tbl[6] = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 4'd11, 16'h6666};
        tbl[7] = '{1'b1, 4'd6,  16'h7777, 1'b1, 4'd12, 16'h8888, 1'b1, 1'b0, 1'b1, 4'd6,  16'h7777};
        tbl[8] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd12, 16'h8888, 1'b0, 1'b1, 1'b1, 4'd12, 16'h8888};

        // reset state
        do_reset();
        check_write("reset", 1'b0, 4'd0, 16'h0000);
        #1;
        check("reset_alu_ready", 32'(bus.alu_ready), 32'd0);
        check("reset_mem_ready", 32'(bus.mem_ready), 32'd0);
        check("reset_busy_a", 32'(bus.busy_a), 32'd0);
        tick();

        // ALU only, r3 <= 1234
        drive_alu(1'b1, 4'd3, 16'h1234);
        #1;
        check("alu_only_ready", 32'(bus.alu_ready), 32'd1);
        check("alu_only_mem_ready", 32'(bus.mem_ready), 32'd0);
        tick();
        drive_alu(1'b0, 4'd0, 16'h0000);
        check_write("alu_only", 1'b1, 4'd3, 16'h1234);
        tick();
        check_write("alu_only_hold", 1'b0, 4'd3, 16'h1234);

        // both valid for 4 cycles after reset: ALU, MEM, ALU, MEM
        do_reset();
        a_s = 4'd1; a_d = 16'ha000;
        m_s = 4'd2; m_d = 16'hb000;
        for (int i = 0; i < 4; i++) begin
            drive_alu(1'b1, a_s, a_d);
            drive_mem(1'b1, m_s, m_d);
            #1;
            check("contend_alu_ready", 32'(bus.alu_ready), 32'((i % 2) == 0));
            check("contend_mem_ready", 32'(bus.mem_ready), 32'((i % 2) == 1));
            tick();
            if ((i % 2) == 0) begin
                check_write("contend_alu", 1'b1, a_s, a_d);
                a_s = a_s + 4'd2;
                a_d = a_d + 16'd1;
            end else begin
                check_write("contend_mem", 1'b1, m_s, m_d);
                m_s = m_s + 4'd2;
                m_d = m_d + 16'd1;
            end
        end

        // table-driven arbitration and write-port vectors
        do_reset();
        foreach (tbl[i]) begin
            drive_alu(tbl[i].av, tbl[i].as, tbl[i].ad);
            drive_mem(tbl[i].mv, tbl[i].ms, tbl[i].md);
            #1;
            check($sformatf("tbl%0d_alu_ready", i), 32'(bus.alu_ready), 32'(tbl[i].exp_ar));
            check($sformatf("tbl%0d_mem_ready", i), 32'(bus.mem_ready), 32'(tbl[i].exp_mr));
            tick();
            check_write($sformatf("tbl%0d", i), tbl[i].exp_we, tbl[i].exp_sel, tbl[i].exp_data);
        end
        idle();

        // reserve r5, MEM writes r5, bit clears the cycle after the strobe
        do_reset();
        bus.reserve = 1'b1; bus.reserve_sel = 4'd5; bus.select_a = 4'd5;
        #1;
        check("res5_ready", 32'(bus.reserve_ready), 32'd1);
        tick();
        bus.reserve = 1'b0;
        #1;
        check("res5_busy_a", 32'(bus.busy_a), 32'd1);
        drive_mem(1'b1, 4'd5, 16'h5a5a);
        #1;
        check("res5_mem_ready", 32'(bus.mem_ready), 32'd1);
        tick();
        drive_mem(1'b0, 4'd0, 16'h0000);
        check_write("res5_write", 1'b1, 4'd5, 16'h5a5a);
        check("res5_busy_in_write", 32'(bus.busy_a), 32'd1);
        tick();
        check("res5_cleared", 32'(bus.busy_a), 32'd0);

        // reserve r7 in the cycle its write lands: set wins
        bus.reserve = 1'b1; bus.reserve_sel = 4'd7; bus.select_a = 4'd7; bus.select_b = 4'd7;
        #1;
        check("res7_first_ready", 32'(bus.reserve_ready), 32'd1);
        tick();
        bus.reserve = 1'b0;
        drive_alu(1'b1, 4'd7, 16'h0777);
        #1;
        check("res7_alu_ready", 32'(bus.alu_ready), 32'd1);
        tick();
        drive_alu(1'b0, 4'd0, 16'h0000);
        check_write("res7_write", 1'b1, 4'd7, 16'h0777);
        bus.reserve = 1'b1;
        #1;
        check("res7_ready_during_write", 32'(bus.reserve_ready), 32'd1);
        check("res7_busy_b_during_write", 32'(bus.busy_b), 32'd1);
        tick();
        bus.reserve = 1'b0;
        #1;
        check("res7_set_wins", 32'(bus.busy_a), 32'd1);
        bus.reserve = 1'b1;
        #1;
        check("res7_not_ready", 32'(bus.reserve_ready), 32'd0);
        tick();
        bus.reserve = 1'b0;
        #1;
        check("res7_still_busy", 32'(bus.busy_a), 32'd1);
        tick();

        // reset mid-transfer: write strobe and pending grant dropped, Busy cleared
        drive_alu(1'b1, 4'd2, 16'hbeef);
        tick();
        check_write("pre_reset_write", 1'b1, 4'd2, 16'hbeef);
        drive_alu(1'b1, 4'd3, 16'hcafe);
        #1;
        rst = 1'b1;
        #1;
        check_write("async_reset", 1'b0, 4'd0, 16'h0000);
        tick();
        check_write("in_reset", 1'b0, 4'd0, 16'h0000);
        tick();
        idle();
        rst = 1'b0;
        tick();
        check_write("post_reset", 1'b0, 4'd0, 16'h0000);
        for (int r = 0; r < 16; r++) begin
            bus.select_a = 4'(r);
            bus.select_b = 4'(15 - r);
            #1;
            check($sformatf("post_reset_busy_a_r%0d", r), 32'(bus.busy_a), 32'd0);
            check($sformatf("post_reset_busy_b_r%0d", r), 32'(bus.busy_b), 32'd0);
        end
        tick();

        // random traffic against a queue/array reference model
        do_reset();
        wr_q.delete();
        foreach (busy_m[r]) busy_m[r] = 1'b0;
        prefer_alu = 1'b1;
        last_wr    = '{sel: '0, data: '0};
        a_v = 1'b0; m_v = 1'b0; a_done = 1'b0; m_done = 1'b0;
        a_s = '0; m_s = '0; a_d = '0; m_d = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            // every granted write appears exactly once, next cycle, in grant order
            if (wr_q.size() > 0) begin
                last_wr = wr_q.pop_front();
                cur_we  = 1'b1;
                cur_sel = last_wr.sel;
            end else begin
                cur_we  = 1'b0;
            end
            check_write("rnd", cur_we, last_wr.sel, last_wr.data);

            // requesters hold their request until granted
            if (!a_v || a_done) begin
                a_v = ($urandom_range(0, 2) != 0);
                a_s = 4'($urandom);
                a_d = 16'($urandom);
            end
            if (!m_v || m_done) begin
                m_v = ($urandom_range(0, 2) != 0);
                m_s = 4'($urandom);
                m_d = 16'($urandom);
            end
            drive_alu(a_v, a_s, a_d);
            drive_mem(m_v, m_s, m_d);
            bus.reserve     = 1'($urandom_range(0, 1));
            bus.reserve_sel = 4'($urandom);
            bus.select_a    = 4'($urandom);
            bus.select_b    = 4'($urandom);
            #1;

            ga = a_v && (!m_v || prefer_alu);
            gm = m_v && !ga;
            rr = !busy_m[bus.reserve_sel] || (cur_we && (cur_sel == bus.reserve_sel));
            check("rnd_alu_ready", 32'(bus.alu_ready), 32'(ga));
            check("rnd_mem_ready", 32'(bus.mem_ready), 32'(gm));
            check("rnd_two_ready", 32'(bus.alu_ready & bus.mem_ready), 32'd0);
            check("rnd_reserve_ready", 32'(bus.reserve_ready), 32'(rr));
            check("rnd_busy_a", 32'(bus.busy_a), 32'(busy_m[bus.select_a]));
            check("rnd_busy_b", 32'(bus.busy_b), 32'(busy_m[bus.select_b]));

            if (cur_we) busy_m[cur_sel] = 1'b0;
            if (bus.reserve && rr) busy_m[bus.reserve_sel] = 1'b1;
            if (ga) begin
                wr_q.push_back('{sel: a_s, data: a_d});
                prefer_alu = 1'b0;
            end else if (gm) begin
                wr_q.push_back('{sel: m_s, data: m_d});
                prefer_alu = 1'b1;
            end
            a_done = ga;
            m_done = gm;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
